// File: rtl/video_timing_gen.sv
// Raster timing generator: shadowed line/frame geometry, registered {VS,HS,DE}
// with active-pixel coordinates, frame counter and genlock counter preset.
module video_timing_gen #(
  parameter int HW  = 12,
  parameter int VW  = 11,
  parameter int FCW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [HW-1:0]      h_total,
  input  logic [HW-1:0]      h_sync,
  input  logic [HW-1:0]      h_start,
  input  logic [HW-1:0]      h_size,
  input  logic [VW-1:0]      v_total,
  input  logic [VW-1:0]      v_sync,
  input  logic [VW-1:0]      v_start,
  input  logic [VW-1:0]      v_size,
  input  logic               hs_pol,
  input  logic               vs_pol,
  input  logic               genlock,
  input  logic [HW+VW-1:0]   vs_reset,
  output logic [2:0]         synco,
  output logic [HW-1:0]      x,
  output logic [VW-1:0]      y,
  output logic [FCW-1:0]     frame_cnt,
  output logic               cfg_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_q, state_d;
  logic [HW-1:0]  hc_q, hc_d, vx_q, vx_d;
  logic [VW-1:0]  vc_q, vc_d, vy_q, vy_d;
  logic [HW-1:0]  ht_q, ht_d, hsy_q, hsy_d, hst_q, hst_d, hsz_q, hsz_d;
  logic [VW-1:0]  vt_q, vt_d, vsy_q, vsy_d, vst_q, vst_d, vsz_q, vsz_d;
  logic           hsp_q, hsp_d, vsp_q, vsp_d;
  logic [FCW-1:0] fc_q, fc_d;
  logic           err_q, err_d;
  logic           gl_q;
  logic [2:0]     synco_q, synco_d;

  logic           cfg_ok, h_end, v_end, gl_ok;
  logic           hs_act, vs_act, de;
  logic [HW-1:0]  gl_h;
  logic [VW-1:0]  gl_v;

  assign gl_h = vs_reset[HW-1:0];
  assign gl_v = vs_reset[HW+VW-1:HW];

  // Sums are widened by one bit so an oversized window cannot wrap into legality.
  assign cfg_ok = (h_total >= HW'(2)) && (v_total >= VW'(2)) &&
                  (h_sync <= h_start) && (v_sync <= v_start) &&
                  (h_size != '0) && (v_size != '0) &&
                  (({1'b0, h_start} + {1'b0, h_size}) <= {1'b0, h_total}) &&
                  (({1'b0, v_start} + {1'b0, v_size}) <= {1'b0, v_total});

  assign h_end = (hc_q == ht_q - 1'b1);
  assign v_end = (vc_q == vt_q - 1'b1);
  assign gl_ok = (state_q == RUN) && genlock && !gl_q && (gl_h < ht_q) && (gl_v < vt_q);

  assign hs_act = (hc_q < hsy_q);
  assign vs_act = (vc_q < vsy_q);
  assign de     = (state_q == RUN) &&
                  (hc_q >= hst_q) && ({1'b0, hc_q} < ({1'b0, hst_q} + {1'b0, hsz_q})) &&
                  (vc_q >= vst_q) && ({1'b0, vc_q} < ({1'b0, vst_q} + {1'b0, vsz_q}));

  always_comb begin
    state_d = state_q;
    hc_d  = hc_q;   vc_d  = vc_q;
    ht_d  = ht_q;   hsy_d = hsy_q;  hst_d = hst_q;  hsz_d = hsz_q;
    vt_d  = vt_q;   vsy_d = vsy_q;  vst_d = vst_q;  vsz_d = vsz_q;
    hsp_d = hsp_q;  vsp_d = vsp_q;
    fc_d  = fc_q;   err_d = err_q;

    unique case (state_q)
      IDLE: begin
        if (en) begin
          if (cfg_ok) begin
            ht_d  = h_total; hsy_d = h_sync; hst_d = h_start; hsz_d = h_size;
            vt_d  = v_total; vsy_d = v_sync; vst_d = v_start; vsz_d = v_size;
            hsp_d = hs_pol;  vsp_d = vs_pol;
            hc_d  = '0;      vc_d  = '0;
            err_d = 1'b0;
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (h_end) begin
          hc_d = '0;
          vc_d = v_end ? '0 : vc_q + 1'b1;
        end else begin
          hc_d = hc_q + 1'b1;
        end
        if (h_end && v_end) begin
          if (!gl_ok) fc_d = fc_q + 1'b1;
          if (en && cfg_ok) begin
            ht_d  = h_total; hsy_d = h_sync; hst_d = h_start; hsz_d = h_size;
            vt_d  = v_total; vsy_d = v_sync; vst_d = v_start; vsz_d = v_size;
            hsp_d = hs_pol;  vsp_d = vs_pol;
            err_d = 1'b0;
          end else begin
            if (en) err_d = 1'b1;
            state_d = IDLE;
          end
        end
        // A genlock preset overrides the wrap but not the reload/idle decision.
        if (gl_ok) begin
          hc_d = gl_h;
          vc_d = gl_v;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (state_q == RUN) begin
      synco_d = {vs_act ~^ vsp_q, hs_act ~^ hsp_q, de};
    end else begin
      synco_d = {~vsp_q, ~hsp_q, 1'b0};
    end
    vx_d = de ? hc_q - hst_q : '0;
    vy_d = de ? vc_q - vst_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hc_q  <= '0;  vc_q  <= '0;
      ht_q  <= '0;  hsy_q <= '0;  hst_q <= '0;  hsz_q <= '0;
      vt_q  <= '0;  vsy_q <= '0;  vst_q <= '0;  vsz_q <= '0;
      hsp_q <= 1'b1; vsp_q <= 1'b1;
      fc_q  <= '0;  err_q <= 1'b0;
      gl_q  <= 1'b0;
      synco_q <= 3'b000;
      vx_q  <= '0;  vy_q  <= '0;
    end else begin
      state_q <= state_d;
      hc_q  <= hc_d;  vc_q  <= vc_d;
      ht_q  <= ht_d;  hsy_q <= hsy_d; hst_q <= hst_d; hsz_q <= hsz_d;
      vt_q  <= vt_d;  vsy_q <= vsy_d; vst_q <= vst_d; vsz_q <= vsz_d;
      hsp_q <= hsp_d; vsp_q <= vsp_d;
      fc_q  <= fc_d;  err_q <= err_d;
      gl_q  <= genlock;
      synco_q <= synco_d;
      vx_q  <= vx_d;  vy_q  <= vy_d;
    end
  end

  assign synco     = synco_q;
  assign x         = vx_q;
  assign y         = vy_q;
  assign frame_cnt = fc_q;
  assign cfg_err   = err_q;

endmodule
